// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache port between LSU loads and store-buffer drains.
// One transaction in flight; loads win unless a store is forced through.
module dcache_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_SEL_WIDTH = 4,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     lsummu2arb_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] lsummu2arb_sel_byte,
    input  logic                      lsummu2arb_req,
    input  logic                      lsummu2arb_fence,
    output logic [DATA_WIDTH-1:0]     arb2lsummu_rdata,
    output logic                      arb2lsummu_ack,
    output logic                      arb2lsummu_fence_done,
    input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
    input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
    input  logic                      stb2arb_req,
    input  logic                      stb2arb_full,
    input  logic                      stb2arb_empty,
    output logic                      arb2stb_ack,
    output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
    output logic                      arb2dcache_w_en,
    output logic                      arb2dcache_req,
    input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
    input  logic                      dcache2arb_ack
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          starve_cnt, starve_cnt_nxt;
    logic [DATA_WIDTH-1:0]     lsu_rdata_nxt;
    logic                      lsu_ack_nxt;
    logic                      fence_done_nxt;
    logic                      stb_ack_nxt;
    logic [ADDR_WIDTH-1:0]     dc_addr_nxt;
    logic [DATA_WIDTH-1:0]     dc_wdata_nxt;
    logic [BYTE_SEL_WIDTH-1:0] dc_sel_nxt;
    logic                      dc_w_en_nxt;
    logic                      dc_req_nxt;

    logic store_force_c;
    logic grant_store_c;
    logic grant_load_c;

    // Grant decision; a pending fence both forces stores and blocks loads.
    always_comb begin
        store_force_c = stb2arb_full | lsummu2arb_fence | (starve_cnt == STARVE_MAX);
        grant_store_c = stb2arb_req & store_force_c;
        grant_load_c  = ~grant_store_c & lsummu2arb_req & ~lsummu2arb_fence;
        if (~grant_load_c & stb2arb_req) begin
            grant_store_c = 1'b1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        lsu_rdata_nxt  = arb2lsummu_rdata;
        lsu_ack_nxt    = 1'b0;
        stb_ack_nxt    = 1'b0;
        fence_done_nxt = lsummu2arb_fence & stb2arb_empty & (state == IDLE) & ~stb2arb_req;
        dc_addr_nxt    = arb2dcache_addr;
        dc_wdata_nxt   = arb2dcache_wdata;
        dc_sel_nxt     = arb2dcache_sel_byte;
        dc_w_en_nxt    = arb2dcache_w_en;
        dc_req_nxt     = arb2dcache_req;

        case (state)
            IDLE: begin
                if (grant_store_c) begin
                    state_nxt      = STORE;
                    starve_cnt_nxt = '0;
                    dc_addr_nxt    = stb2arb_addr;
                    dc_wdata_nxt   = stb2arb_wdata;
                    dc_sel_nxt     = stb2arb_sel_byte;
                    dc_w_en_nxt    = 1'b1;
                    dc_req_nxt     = 1'b1;
                end else if (grant_load_c) begin
                    state_nxt    = LOAD;
                    dc_addr_nxt  = lsummu2arb_addr;
                    dc_wdata_nxt = '0;
                    dc_sel_nxt   = lsummu2arb_sel_byte;
                    dc_w_en_nxt  = 1'b0;
                    dc_req_nxt   = 1'b1;
                    if (stb2arb_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (dcache2arb_ack) begin
                    state_nxt     = RESP;
                    dc_req_nxt    = 1'b0;
                    lsu_ack_nxt   = 1'b1;
                    lsu_rdata_nxt = dcache2arb_rdata;
                end
            end
            STORE: begin
                if (dcache2arb_ack) begin
                    state_nxt   = RESP;
                    dc_req_nxt  = 1'b0;
                    stb_ack_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt     = IDLE;
                lsu_rdata_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            starve_cnt            <= '0;
            arb2lsummu_rdata      <= '0;
            arb2lsummu_ack        <= 1'b0;
            arb2lsummu_fence_done <= 1'b0;
            arb2stb_ack           <= 1'b0;
            arb2dcache_addr       <= '0;
            arb2dcache_wdata      <= '0;
            arb2dcache_sel_byte   <= '0;
            arb2dcache_w_en       <= 1'b0;
            arb2dcache_req        <= 1'b0;
        end else begin
            state                 <= state_nxt;
            starve_cnt            <= starve_cnt_nxt;
            arb2lsummu_rdata      <= lsu_rdata_nxt;
            arb2lsummu_ack        <= lsu_ack_nxt;
            arb2lsummu_fence_done <= fence_done_nxt;
            arb2stb_ack           <= stb_ack_nxt;
            arb2dcache_addr       <= dc_addr_nxt;
            arb2dcache_wdata      <= dc_wdata_nxt;
            arb2dcache_sel_byte   <= dc_sel_nxt;
            arb2dcache_w_en       <= dc_w_en_nxt;
            arb2dcache_req        <= dc_req_nxt;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: queue-driven requesters, a randomized dcache
// responder and a transaction-level reference model checked every cycle.
module tb_dcache_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned SL = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] lsummu2arb_addr = '0;
    logic [SW-1:0] lsummu2arb_sel_byte = '0;
    logic          lsummu2arb_req = 1'b0;
    logic          lsummu2arb_fence = 1'b0;
    logic [DW-1:0] arb2lsummu_rdata;
    logic          arb2lsummu_ack;
    logic          arb2lsummu_fence_done;
    logic [AW-1:0] stb2arb_addr = '0;
    logic [DW-1:0] stb2arb_wdata = '0;
    logic [SW-1:0] stb2arb_sel_byte = '0;
    logic          stb2arb_req = 1'b0;
    logic          stb2arb_full = 1'b0;
    logic          stb2arb_empty = 1'b1;
    logic          arb2stb_ack;
    logic [AW-1:0] arb2dcache_addr;
    logic [DW-1:0] arb2dcache_wdata;
    logic [SW-1:0] arb2dcache_sel_byte;
    logic          arb2dcache_w_en;
    logic          arb2dcache_req;
    logic [DW-1:0] dcache2arb_rdata = '0;
    logic          dcache2arb_ack = 1'b0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lsummu2arb_addr(lsummu2arb_addr), .lsummu2arb_sel_byte(lsummu2arb_sel_byte),
        .lsummu2arb_req(lsummu2arb_req), .lsummu2arb_fence(lsummu2arb_fence),
        .arb2lsummu_rdata(arb2lsummu_rdata), .arb2lsummu_ack(arb2lsummu_ack),
        .arb2lsummu_fence_done(arb2lsummu_fence_done),
        .stb2arb_addr(stb2arb_addr), .stb2arb_wdata(stb2arb_wdata),
        .stb2arb_sel_byte(stb2arb_sel_byte), .stb2arb_req(stb2arb_req),
        .stb2arb_full(stb2arb_full), .stb2arb_empty(stb2arb_empty),
        .arb2stb_ack(arb2stb_ack),
        .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
        .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_w_en(arb2dcache_w_en),
        .arb2dcache_req(arb2dcache_req),
        .dcache2arb_rdata(dcache2arb_rdata), .dcache2arb_ack(dcache2arb_ack)
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Requester queues and stimulus knobs
    req_t        ldq[$];
    req_t        stq[$];
    bit          fence_r = 1'b0;
    bit          force_full = 1'b0;
    int unsigned full_lvl = 99;
    int unsigned lat_lo = 0, lat_hi = 0, wait_cnt = 0;
    bit          spur_en = 1'b0;
    bit          fixed_rd_en = 1'b0;
    logic [DW-1:0] fixed_rd = '0;
    int unsigned n_lack_seen = 0, n_sack_seen = 0;
    logic [DW-1:0] cap_rdata = '0;

    // Reference model: one transaction at a time, then a one-cycle response slot
    bit            m_busy = 1'b0, m_resp = 1'b0;
    int unsigned   m_starve = 0;
    string         glog = "";
    logic [DW-1:0] e_rdata = '0;
    logic          e_lack = 1'b0, e_fd = 1'b0, e_sack = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [SW-1:0] e_sel = '0;
    logic          e_wen = 1'b0, e_req = 1'b0;

    // Inputs as the DUT will sample them on the coming edge
    bit            s_ldreq, s_fence, s_streq, s_full, s_empty, s_dack;
    logic [AW-1:0] s_ldaddr, s_staddr;
    logic [SW-1:0] s_ldsel, s_stsel;
    logic [DW-1:0] s_stdata, s_drdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        n_chk++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_resp = 1'b0; m_starve = 0;
        e_rdata = '0; e_lack = 1'b0; e_fd = 1'b0; e_sack = 1'b0;
        e_addr = '0; e_wdata = '0; e_sel = '0; e_wen = 1'b0; e_req = 1'b0;
    endtask

    task automatic model_edge();
        bit idle, force_st, g_ld, g_st;
        idle = !m_busy && !m_resp;
        e_fd = s_fence && s_empty && idle && !s_streq;
        if (m_resp) begin
            m_resp = 1'b0; e_lack = 1'b0; e_sack = 1'b0; e_rdata = '0;
        end else if (m_busy) begin
            if (s_dack) begin
                m_busy = 1'b0; m_resp = 1'b1; e_req = 1'b0;
                if (e_wen) e_sack = 1'b1;
                else begin e_lack = 1'b1; e_rdata = s_drdata; end
            end
        end else begin
            force_st = s_full || s_fence || (m_starve == SL);
            g_ld = s_ldreq && !s_fence && !(s_streq && force_st);
            g_st = s_streq && !g_ld;
            if (g_ld) begin
                m_busy = 1'b1; e_req = 1'b1; e_wen = 1'b0;
                e_addr = s_ldaddr; e_wdata = '0; e_sel = s_ldsel;
                if (s_streq && m_starve < SL) m_starve++;
                glog = {glog, "L"};
            end else if (g_st) begin
                m_busy = 1'b1; e_req = 1'b1; e_wen = 1'b1;
                e_addr = s_staddr; e_wdata = s_stdata; e_sel = s_stsel;
                m_starve = 0;
                glog = {glog, "S"};
            end
        end
    endtask

    task automatic drive_inputs();
        lsummu2arb_req = (ldq.size() != 0);
        if (ldq.size() != 0) begin
            lsummu2arb_addr = ldq[0].addr; lsummu2arb_sel_byte = ldq[0].sel;
        end else begin
            lsummu2arb_addr = $urandom; lsummu2arb_sel_byte = SW'($urandom);
        end
        stb2arb_req = (stq.size() != 0);
        stb2arb_empty = (stq.size() == 0);
        stb2arb_full = force_full || (stq.size() >= full_lvl);
        if (stq.size() != 0) begin
            stb2arb_addr = stq[0].addr; stb2arb_wdata = stq[0].data; stb2arb_sel_byte = stq[0].sel;
        end
        lsummu2arb_fence = fence_r;
    endtask

    task automatic respond();
        if (dcache2arb_ack) begin
            dcache2arb_ack = 1'b0;
        end else if (arb2dcache_req) begin
            if (wait_cnt == 0) begin
                dcache2arb_ack = 1'b1;
                dcache2arb_rdata = fixed_rd_en ? fixed_rd : DW'($urandom);
                wait_cnt = $urandom_range(lat_hi, lat_lo);
            end else begin
                wait_cnt--;
            end
        end else if (spur_en && $urandom_range(7, 0) == 0) begin
            dcache2arb_ack = 1'b1;
            dcache2arb_rdata = DW'($urandom);
        end
    endtask

    task automatic step();
        s_ldreq = lsummu2arb_req; s_fence = lsummu2arb_fence; s_streq = stb2arb_req;
        s_full = stb2arb_full; s_empty = stb2arb_empty; s_dack = dcache2arb_ack;
        s_ldaddr = lsummu2arb_addr; s_ldsel = lsummu2arb_sel_byte;
        s_staddr = stb2arb_addr; s_stdata = stb2arb_wdata; s_stsel = stb2arb_sel_byte;
        s_drdata = dcache2arb_rdata;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cycle_outputs",
            128'({arb2lsummu_rdata, arb2lsummu_ack, arb2lsummu_fence_done, arb2stb_ack,
                  arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte, arb2dcache_w_en,
                  arb2dcache_req}),
            128'({e_rdata, e_lack, e_fd, e_sack, e_addr, e_wdata, e_sel, e_wen, e_req}));
        if (arb2lsummu_ack) begin n_lack_seen++; cap_rdata = arb2lsummu_rdata; end
        if (arb2stb_ack) n_sack_seen++;
        if (e_lack && ldq.size() != 0) void'(ldq.pop_front());
        if (e_sack && stq.size() != 0) void'(stq.pop_front());
        respond();
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        req_t r;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            128'({arb2lsummu_rdata, arb2lsummu_ack, arb2lsummu_fence_done, arb2stb_ack,
                  arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte, arb2dcache_w_en,
                  arb2dcache_req}), 128'(0));
        rst_n = 1'b1;
        drive_inputs();
        run(2);

        // Single load with a fixed two-cycle dcache delay
        lat_lo = 2; lat_hi = 2; wait_cnt = 2; fixed_rd_en = 1'b1; fixed_rd = 32'hDEADBEEF;
        n_lack_seen = 0; glog = "";
        ldq.push_back('{addr: 32'h40, data: '0, sel: 4'hF});
        drive_inputs();
        step();
        chk("load_req_latency", 128'({arb2dcache_req, arb2dcache_w_en, arb2dcache_addr}),
            128'({1'b1, 1'b0, 32'h40}));
        run(10);
        chk("load_ack_count", 128'(n_lack_seen), 128'(1));
        chk("load_rdata", 128'(cap_rdata), 128'(32'hDEADBEEF));
        chk_str("load_grants", glog, "L");
        fixed_rd_en = 1'b0;

        // Single store held until a three-cycle dcache ack
        lat_lo = 3; lat_hi = 3; wait_cnt = 3; n_sack_seen = 0;
        stq.push_back('{addr: 32'h1C, data: 32'hA5A5A5A5, sel: 4'b0011});
        drive_inputs();
        step();
        chk("store_fields", 128'({arb2dcache_addr, arb2dcache_wdata, arb2dcache_sel_byte,
                                  arb2dcache_w_en, arb2dcache_req}),
            128'({32'h1C, 32'hA5A5A5A5, 4'b0011, 1'b1, 1'b1}));
        run(10);
        chk("store_ack_count", 128'(n_sack_seen), 128'(1));

        // Full store buffer overrides load priority
        lat_lo = 0; lat_hi = 0; wait_cnt = 0; glog = ""; force_full = 1'b1;
        ldq.push_back('{addr: 32'h100, data: '0, sel: 4'h1});
        stq.push_back('{addr: 32'h200, data: 32'h1234, sel: 4'h2});
        drive_inputs();
        run(15);
        chk_str("full_grants", glog, "SL");
        force_full = 1'b0;

        // Starvation limit with both sides requesting continuously
        glog = "";
        for (int i = 0; i < 8; i++) ldq.push_back('{addr: AW'(32'h300 + i * 4), data: '0, sel: 4'hF});
        for (int i = 0; i < 2; i++) stq.push_back('{addr: AW'(32'h400 + i * 4), data: DW'(i + 7), sel: 4'hC});
        drive_inputs();
        run(60);
        chk_str("starve_grants", glog, "LLLLSLLLLS");
        chk("starve_drained", 128'({ldq.size(), stq.size()}), 128'(0));

        // Fence: stores drain, load blocked until fence drops
        glog = ""; fence_r = 1'b1;
        for (int i = 0; i < 3; i++) stq.push_back('{addr: AW'(32'h500 + i * 4), data: DW'(i), sel: 4'h3});
        ldq.push_back('{addr: 32'h600, data: '0, sel: 4'h5});
        drive_inputs();
        run(40);
        chk_str("fence_grants", glog, "SSS");
        chk("fence_done_high", 128'(arb2lsummu_fence_done), 128'(1));
        fence_r = 1'b0;
        drive_inputs();
        step();
        chk("fence_done_drop", 128'(arb2lsummu_fence_done), 128'(0));
        run(10);
        chk_str("fence_release", glog, "SSSL");

        // Asynchronous reset while a store awaits its dcache ack
        lat_lo = 6; lat_hi = 6; wait_cnt = 6; n_sack_seen = 0;
        stq.push_back('{addr: 32'h700, data: 32'hCAFEF00D, sel: 4'h9});
        drive_inputs();
        run(3);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_store", 128'({arb2dcache_req, arb2stb_ack}), 128'(0));
        model_reset();
        dcache2arb_ack = 1'b0; wait_cnt = 1; lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", 128'({arb2stb_ack, arb2dcache_req, arb2dcache_addr}), 128'(0));
        rst_n = 1'b1;
        run(15);
        chk("reissue_store_ack", 128'({n_sack_seen, stq.size()}), 128'({32'd1, 32'd0}));

        // Randomized traffic with spurious dcache acks
        lat_lo = 0; lat_hi = 3; spur_en = 1'b1; full_lvl = 6;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(5, 0) == 0 && ldq.size() < 4) begin
                r.addr = $urandom; r.data = '0; r.sel = SW'($urandom);
                ldq.push_back(r);
            end
            if ($urandom_range(4, 0) == 0 && stq.size() < 8) begin
                r.addr = $urandom; r.data = $urandom; r.sel = SW'($urandom);
                stq.push_back(r);
            end
            if ($urandom_range(39, 0) == 0) fence_r = !fence_r;
            drive_inputs();
            step();
        end
        fence_r = 1'b0; spur_en = 1'b0;
        drive_inputs();
        run(150);
        chk("random_drained", 128'({ldq.size(), stq.size()}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
